// File: rtl/mem_sched_pkg.sv
// Shared definitions for the memory scheduler: requester IDs and FSM states.
package mem_sched_pkg;

    localparam logic [1:0] ID_IC = 2'd0;
    localparam logic [1:0] ID_DC = 2'd1;
    localparam logic [1:0] ID_UC = 2'd2;

    localparam int unsigned NUM_RD = 3;

    typedef enum logic [1:0] {
        R_IDLE,
        R_ADDR,
        R_WAIT,
        R_DONE
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_ADDR,
        W_WAIT,
        W_DONE
    } wr_state_t;

    // Requester ID of a one-hot read grant (bit 0 icache, 1 dcache, 2 uncache).
    function automatic logic [1:0] gnt_to_id(input logic [2:0] gnt);
        logic [1:0] id;
        id = ID_IC;
        if (gnt[1]) id = ID_DC;
        if (gnt[2]) id = ID_UC;
        return id;
    endfunction

endpackage

// File: rtl/mem_sched_rd_grant.sv
// Read grant selection for three requesters. Round-robin when ARB_RR_EN is
// defined, otherwise fixed priority icache > dcache > uncache.
module rd_grant
    import mem_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req_i,
    input  logic       take_i,
    output logic [2:0] gnt_o
);

`ifdef ARB_RR_EN
    // Index of the requester with highest priority this round.
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] idx;
    logic       found;

    // Rotating priority search starting at the pointer.
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            idx = 2'((int unsigned'(ptr_q) + k) % NUM_RD);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    // Pointer moves to the requester after the one just granted.
    always_comb begin
        ptr_d = ptr_q;
        if (take_i) begin
            case (gnt_o)
                3'b001:  ptr_d = 2'd1;
                3'b010:  ptr_d = 2'd2;
                3'b100:  ptr_d = 2'd0;
                default: ptr_d = ptr_q;
            endcase
        end
    end

    // Pointer register, starts at icache.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end
`else
    // Fixed priority: lowest index wins.
    always_comb begin
        gnt_o = '0;
        if (req_i[0])      gnt_o[0] = 1'b1;
        else if (req_i[1]) gnt_o[1] = 1'b1;
        else if (req_i[2]) gnt_o[2] = 1'b1;
    end

    logic unused_fixed;
    assign unused_fixed = ^{clk, rst, take_i};
`endif

endmodule

// File: rtl/mem_sched.sv
// Memory scheduler: arbitrates icache/dcache/uncached reads onto one read
// channel and dcache/uncached writes onto one write channel. Optional macro
// ARB_RR_EN selects round-robin read arbitration.
module mem_sched
    import mem_sched_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ic_req_i,
    input  logic [ADDR_W-1:0] ic_addr_i,
    output logic              ic_done_o,
    input  logic              dc_rreq_i,
    input  logic              dc_wreq_i,
    input  logic [ADDR_W-1:0] dc_addr_i,
    input  logic [DATA_W-1:0] dc_wdata_i,
    input  logic [7:0]        dc_mask_i,
    output logic              dc_rdone_o,
    output logic              dc_wdone_o,
    input  logic              uc_rreq_i,
    input  logic              uc_wreq_i,
    input  logic [ADDR_W-1:0] uc_addr_i,
    input  logic [DATA_W-1:0] uc_wdata_i,
    input  logic [7:0]        uc_mask_i,
    output logic              uc_rdone_o,
    output logic              uc_wdone_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              ar_e_o,
    output logic [1:0]        ar_id_o,
    output logic [ADDR_W-1:0] ar_addr_o,
    input  logic              ar_ready_i,
    input  logic              r_over_i,
    input  logic [1:0]        r_id_i,
    input  logic [DATA_W-1:0] r_data_i,
    output logic              aw_e_o,
    output logic [ADDR_W-1:0] aw_addr_o,
    output logic [DATA_W-1:0] w_data_o,
    output logic [7:0]        w_mask_o,
    input  logic              aw_ready_i,
    input  logic              b_over_i
);

    rd_state_t         rd_state_q;
    wr_state_t         wr_state_q;

    logic              ar_e_q;
    logic [1:0]        ar_id_q;
    logic [ADDR_W-1:0] ar_addr_q;
    logic [2:0]        rdone_q;
    logic [DATA_W-1:0] rdata_q;

    logic              aw_e_q;
    logic              wr_dc_q;
    logic [ADDR_W-1:0] aw_addr_q;
    logic [DATA_W-1:0] w_data_q;
    logic [7:0]        w_mask_q;
    logic [1:0]        wdone_q;

    logic              wr_holds_dc;
    logic              dc_rd_ok;
    logic [2:0]        rd_req;
    logic [2:0]        rd_gnt;
    logic              rd_take;
    logic [ADDR_W-1:0] gnt_addr;

    // A dcache refill waits until any pending or in-flight writeback is done.
    assign wr_holds_dc = (wr_state_q != W_IDLE) && wr_dc_q;
    assign dc_rd_ok    = dc_rreq_i && !dc_wreq_i && !wr_holds_dc;
    assign rd_req      = {uc_rreq_i, dc_rd_ok, ic_req_i};
    assign rd_take     = (rd_state_q == R_IDLE) && (rd_gnt != 3'b000);

    rd_grant u_rd_grant (
        .clk    (clk),
        .rst    (rst),
        .req_i  (rd_req),
        .take_i (rd_take),
        .gnt_o  (rd_gnt)
    );

    // Address of the requester the arbiter is currently granting.
    always_comb begin
        gnt_addr = '0;
        case (rd_gnt)
            3'b001:  gnt_addr = ic_addr_i;
            3'b010:  gnt_addr = dc_addr_i;
            3'b100:  gnt_addr = uc_addr_i;
            default: gnt_addr = '0;
        endcase
    end

    // Read FSM with registered channel outputs and done pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state_q <= R_IDLE;
            ar_e_q     <= 1'b0;
            ar_id_q    <= '0;
            ar_addr_q  <= '0;
            rdone_q    <= '0;
            rdata_q    <= '0;
        end else begin
            rdone_q <= '0;
            case (rd_state_q)
                R_IDLE: begin
                    if (rd_take) begin
                        rd_state_q <= R_ADDR;
                        ar_e_q     <= 1'b1;
                        ar_id_q    <= gnt_to_id(rd_gnt);
                        ar_addr_q  <= gnt_addr;
                    end
                end
                R_ADDR: begin
                    if (ar_ready_i) begin
                        rd_state_q <= R_WAIT;
                        ar_e_q     <= 1'b0;
                    end
                end
                R_WAIT: begin
                    if (r_over_i && (r_id_i == ar_id_q)) begin
                        rd_state_q <= R_DONE;
                        rdata_q    <= r_data_i;
                        rdone_q    <= {ar_id_q == ID_UC, ar_id_q == ID_DC, ar_id_q == ID_IC};
                    end
                end
                R_DONE:  rd_state_q <= R_IDLE;
                default: rd_state_q <= R_IDLE;
            endcase
        end
    end

    // Write FSM, dcache writeback always wins over uncached write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state_q <= W_IDLE;
            aw_e_q     <= 1'b0;
            wr_dc_q    <= 1'b0;
            aw_addr_q  <= '0;
            w_data_q   <= '0;
            w_mask_q   <= '0;
            wdone_q    <= '0;
        end else begin
            wdone_q <= '0;
            case (wr_state_q)
                W_IDLE: begin
                    if (dc_wreq_i || uc_wreq_i) begin
                        wr_state_q <= W_ADDR;
                        aw_e_q     <= 1'b1;
                        wr_dc_q    <= dc_wreq_i;
                        aw_addr_q  <= dc_wreq_i ? dc_addr_i  : uc_addr_i;
                        w_data_q   <= dc_wreq_i ? dc_wdata_i : uc_wdata_i;
                        w_mask_q   <= dc_wreq_i ? dc_mask_i  : uc_mask_i;
                    end
                end
                W_ADDR: begin
                    if (aw_ready_i) begin
                        wr_state_q <= W_WAIT;
                        aw_e_q     <= 1'b0;
                    end
                end
                W_WAIT: begin
                    if (b_over_i) begin
                        wr_state_q <= W_DONE;
                        wdone_q    <= {!wr_dc_q, wr_dc_q};
                    end
                end
                W_DONE:  wr_state_q <= W_IDLE;
                default: wr_state_q <= W_IDLE;
            endcase
        end
    end

    assign ic_done_o  = rdone_q[0];
    assign dc_rdone_o = rdone_q[1];
    assign uc_rdone_o = rdone_q[2];
    assign rdata_o    = rdata_q;
    assign ar_e_o     = ar_e_q;
    assign ar_id_o    = ar_id_q;
    assign ar_addr_o  = ar_addr_q;

    assign dc_wdone_o = wdone_q[0];
    assign uc_wdone_o = wdone_q[1];
    assign aw_e_o     = aw_e_q;
    assign aw_addr_o  = aw_addr_q;
    assign w_data_o   = w_data_q;
    assign w_mask_o   = w_mask_q;

endmodule

// File: doc/mem_sched.md
MEM_SCHED -- requirements
Module: mem_sched

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning address width.
REQ-002 SHALL have parameter DATA_W, default 64, meaning data beat width.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 ic_req_i, ic_addr_i[ADDR_W]  input  icache refill read request and address.
REQ-006 ic_done_o  output  1  one-cycle pulse, read data valid for icache.
REQ-007 dc_rreq_i, dc_wreq_i, dc_addr_i[ADDR_W], dc_wdata_i[DATA_W], dc_mask_i[8]  input  dcache refill read request, writeback request, address, data, byte mask.
REQ-008 dc_rdone_o, dc_wdone_o  output  1  one-cycle completion pulses.
REQ-009 uc_rreq_i, uc_wreq_i, uc_addr_i[ADDR_W], uc_wdata_i[DATA_W], uc_mask_i[8]  input  uncached device read/write request, address, data, mask.
REQ-010 uc_rdone_o, uc_wdone_o  output  1  one-cycle completion pulses.
REQ-011 rdata_o[DATA_W]  output  registered read data, valid during any read done pulse.
REQ-012 ar_e_o, ar_id_o[2], ar_addr_o[ADDR_W]  output  read address valid, ID (0 icache, 1 dcache, 2 uncache), address; ar_ready_i, r_over_i, r_id_i[2], r_data_i[DATA_W] input.
REQ-013 aw_e_o, aw_addr_o[ADDR_W], w_data_o[DATA_W], w_mask_o[8]  output  write request; aw_ready_i, b_over_i input.

Function
REQ-014 Requests SHALL be level-held by requesters until their done pulse; scheduler SHALL not drop a granted request.
REQ-015 Read FSM SHALL have states R_IDLE, R_ADDR, R_WAIT, R_DONE: R_IDLE->R_ADDR on any eligible read request (grant latched); R_ADDR->R_WAIT when ar_ready_i; R_WAIT->R_DONE when r_over_i and r_id_i equals granted ID (data latched into rdata_o); R_DONE->R_IDLE unconditionally.
REQ-016 ar_e_o SHALL be high only in R_ADDR; ar_id_o/ar_addr_o SHALL be stable from latched grant throughout R_ADDR and R_WAIT.
REQ-017 r_over_i with mismatched r_id_i SHALL be ignored.
REQ-018 Write FSM SHALL have states W_IDLE, W_ADDR, W_WAIT, W_DONE with the same transitions using aw_ready_i and b_over_i; write priority dcache over uncache, fixed.
REQ-019 Read and write FSMs SHALL run concurrently and independently.
REQ-020 A dcache read SHALL not be granted while dc_wreq_i is high or the write FSM holds a dcache grant (writeback precedes refill).
REQ-021 Done pulse SHALL assert in R_DONE/W_DONE for exactly the granted requester; minimum read latency request->done is 3 cycles with ar_ready_i and r_over_i high immediately.
REQ-022 Simultaneous read done and write done SHALL both be pulsed in the same cycle.

Reset
REQ-023 On rst both FSMs SHALL enter IDLE immediately; all outputs 0, rdata_o 0, round-robin pointer to icache.
REQ-024 Reset mid-transaction SHALL abandon it without a done pulse; later r_over_i/b_over_i SHALL be ignored in IDLE.

Configuration
REQ-025 With ARB_RR_EN defined, read grant SHALL rotate round-robin starting after the last granted requester; without it, fixed priority icache > dcache > uncache.

Structure
REQ-026 Requester ID constants and FSM state encodings SHALL reside in the shared defines package.
REQ-027 Grant selection SHALL be a sub-module rd_grant (3 requests in, one-hot grant out, pointer state when ARB_RR_EN).

Verification
REQ-028 icache read 0x8000_0000, ar_ready_i and r_over_i immediate, r_data_i=0x1122334455667788 -> ic_done_o pulse at cycle 3, rdata_o=0x1122334455667788.
REQ-029 ic_req_i, dc_rreq_i, uc_rreq_i all held high -> grant order ic,dc,uc,ic (ARB_RR_EN) or ic,ic,... (without).
REQ-030 dc_wreq_i and dc_rreq_i same cycle addr 0x8000_1000 -> aw_e_o first; ar_e_o for dcache only after dc_wdone_o.
REQ-031 dcache read pending, r_over_i with r_id_i=0 -> no done, FSM stays R_WAIT.
REQ-032 rst asserted in R_WAIT, then r_over_i -> no done pulse, all outputs 0.
REQ-033 concurrent uc write and ic read finishing same cycle -> uc_wdone_o and ic_done_o both pulse.
